// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the four-requester mux arbiter.
// Defines the requester count, the select and data word types, and a select increment helper.
package mux_arb_pkg;

    localparam int NREQ = 4;

    typedef logic [1:0] sel_t;
    typedef logic [3:0] word_t;

    function automatic sel_t next_sel(input sel_t idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/mux4.sv
// 4-bit 4:1 data multiplexer shared by all requesters.
module mux4
    import mux_arb_pkg::*;
(
    input  word_t d0,
    input  word_t d1,
    input  word_t d2,
    input  word_t d3,
    input  sel_t  s,
    output word_t y
);

    // select one of the four input words
    always_comb begin
        y = 4'h0;
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = 4'h0;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping modulo 4.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [3:0] req,
    input  sel_t       ptr,
    output logic [3:0] grant,
    output sel_t       g,
    output logic       hit
);

    // scan ptr, ptr+1, ptr+2, ptr+3 and keep the first active index
    always_comb begin
        sel_t idx_v;
        g     = 2'd0;
        hit   = 1'b0;
        idx_v = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!hit && req[idx_v]) begin
                hit = 1'b1;
                g   = idx_v;
            end else begin
                hit = hit;
            end
            idx_v = next_sel(idx_v);
        end
        if (hit) begin
            grant = 4'b0001 << g;
        end else begin
            grant = 4'b0000;
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 mux among four valid/ready requesters
// and holds the selected word in a one-entry output register.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int START_PTR = 0,
    parameter int BURST     = 1
)(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req_valid,
    input  logic [3:0] req_data0,
    input  logic [3:0] req_data1,
    input  logic [3:0] req_data2,
    input  logic [3:0] req_data3,
    output logic [3:0] req_ready,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic [1:0] out_src,
    input  logic       out_ready,
    output logic       busy
);

    localparam sel_t       START_SEL = sel_t'(START_PTR);
    localparam logic [3:0] BURST_M1  = 4'(BURST - 1);

    sel_t       ptr_r;
    logic [3:0] burst_cnt_r;
    logic       out_valid_r;
    word_t      out_data_r;
    sel_t       out_src_r;

    logic [3:0] grant_s;
    sel_t       g_s;
    logic       hit_s;
    word_t      mux_s;
    logic       load_en_s;
    logic       xfer_s;
    logic [3:0] eff_cnt_s;
    logic       keep_s;

    rr_pick4 u_pick (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .g     (g_s),
        .hit   (hit_s)
    );

    mux4 u_mux (
        .d0 (req_data0),
        .d1 (req_data1),
        .d2 (req_data2),
        .d3 (req_data3),
        .s  (g_s),
        .y  (mux_s)
    );

    assign load_en_s = !out_valid_r || out_ready;
    assign xfer_s    = hit_s && load_en_s && reset_n;
    assign req_ready = (reset_n && load_en_s) ? grant_s : 4'b0000;

    // a new requester starts a fresh burst; the same one continues its count
    always_comb begin
        if (g_s == out_src_r) begin
            eff_cnt_s = burst_cnt_r;
        end else begin
            eff_cnt_s = 4'd0;
        end
        keep_s = (eff_cnt_s < BURST_M1);
    end

    // output register, rotation pointer and burst counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 4'h0;
            out_src_r   <= 2'd0;
            ptr_r       <= START_SEL;
            burst_cnt_r <= 4'd0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= mux_s;
            out_src_r   <= g_s;
            if (keep_s) begin
                ptr_r       <= g_s;
                burst_cnt_r <= eff_cnt_s + 4'd1;
            end else begin
                ptr_r       <= next_sel(g_s);
                burst_cnt_r <= 4'd0;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign busy      = out_valid_r || (|req_valid);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one pure round-robin instance and one BURST=3 instance.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req_valid, req_valid_b;
    logic [3:0] req_ready, req_ready_b;
    logic       out_valid, out_valid_b;
    logic [3:0] out_data, out_data_b;
    logic [1:0] out_src, out_src_b;
    logic       out_ready, out_ready_b;
    logic       busy, busy_b;
    logic [3:0] d0, d1, d2, d3;

    int n_assert = 0;
    int n_fail   = 0;

    mux4_rr_arbiter #(.START_PTR(0), .BURST(1)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
        .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready), .busy(busy)
    );

    mux4_rr_arbiter #(.START_PTR(0), .BURST(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid_b),
        .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
        .req_ready(req_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
        .out_src(out_src_b), .out_ready(out_ready_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
        reset_n = 1'b0; req_valid = 4'hF; out_ready = 1'b1;
        req_valid_b = 4'h0; out_ready_b = 1'b1;

        // reset with all requesters valid
        step(); step();
        chk("rst_ready", 8'(req_ready), 8'h0);
        chk("rst_valid", 8'(out_valid), 8'h0);
        chk("rst_data",  8'(out_data),  8'h0);
        chk("rst_src",   8'(out_src),   8'h0);
        chk("rst_busy",  8'(busy),      8'h1);

        // round robin, one word per cycle
        reset_n = 1'b1; #1;
        chk("rr_ready0", 8'(req_ready), 8'h1);
        step();
        chk("rr_valid0", 8'(out_valid), 8'h1);
        chk("rr_src0",   8'(out_src),   8'h0);
        chk("rr_data0",  8'(out_data),  8'hA);
        chk("rr_ready1", 8'(req_ready), 8'h2);
        step(); chk("rr_src1", 8'(out_src), 8'h1); chk("rr_data1", 8'(out_data), 8'hB);
        step(); chk("rr_src2", 8'(out_src), 8'h2); chk("rr_data2", 8'(out_data), 8'hC);
        step(); chk("rr_src3", 8'(out_src), 8'h3); chk("rr_data3", 8'(out_data), 8'hD);
        step(); chk("rr_src4", 8'(out_src), 8'h0); chk("rr_data4", 8'(out_data), 8'hA);

        // stall holding 4'hA
        out_ready = 1'b0; #1;
        chk("stall_ready", 8'(req_ready), 8'h0);
        step(); step();
        chk("stall_valid", 8'(out_valid), 8'h1);
        chk("stall_data",  8'(out_data),  8'hA);
        chk("stall_src",   8'(out_src),   8'h0);
        chk("stall_ready2", 8'(req_ready), 8'h0);
        out_ready = 1'b1; #1;
        chk("rel_ready", 8'(req_ready), 8'h2);
        step();
        chk("rel_src",  8'(out_src),  8'h1);
        chk("rel_data", 8'(out_data), 8'hB);

        // bring ptr to 1 via a lone grant to requester 0, then sparse 1001
        req_valid = 4'b0001; #1;
        chk("lone_ready", 8'(req_ready), 8'h1);
        step(); chk("lone_src", 8'(out_src), 8'h0);
        req_valid = 4'b1001; #1;
        chk("sp_ready0", 8'(req_ready), 8'h8);
        step(); chk("sp_src0", 8'(out_src), 8'h3); chk("sp_data0", 8'(out_data), 8'hD);
        chk("sp_ready1", 8'(req_ready), 8'h1);
        step(); chk("sp_src1", 8'(out_src), 8'h0);
        step(); chk("sp_src2", 8'(out_src), 8'h3);

        // pop without load empties the register
        req_valid = 4'b0000;
        step();
        chk("pop_valid", 8'(out_valid), 8'h0);
        chk("pop_busy",  8'(busy),      8'h0);

        // reset while FULL and stalled
        req_valid = 4'b0100;
        step();
        chk("full_src",  8'(out_src),  8'h2);
        chk("full_data", 8'(out_data), 8'hC);
        out_ready = 1'b0; req_valid = 4'hF; reset_n = 1'b0; #1;
        chk("mrst_ready", 8'(req_ready), 8'h0);
        step();
        chk("mrst_valid", 8'(out_valid), 8'h0);
        chk("mrst_data",  8'(out_data),  8'h0);
        chk("mrst_src",   8'(out_src),   8'h0);
        reset_n = 1'b1; out_ready = 1'b1; #1;
        chk("mrst_ptr", 8'(req_ready), 8'h1);
        step();
        chk("mrst_src1", 8'(out_src), 8'h0);
        chk("mrst_busy", 8'(busy),    8'h1);

        // burst of 3 between requesters 0 and 1
        req_valid_b = 4'b0011; #1;
        chk("b_ready0", 8'(req_ready_b), 8'h1);
        step(); chk("b_src0", 8'(out_src_b), 8'h0);
        step(); chk("b_src1", 8'(out_src_b), 8'h0);
        step(); chk("b_src2", 8'(out_src_b), 8'h0);
        step(); chk("b_src3", 8'(out_src_b), 8'h1); chk("b_data3", 8'(out_data_b), 8'hB);
        step(); chk("b_src4", 8'(out_src_b), 8'h1);
        step(); chk("b_src5", 8'(out_src_b), 8'h1);
        step(); chk("b_src6", 8'(out_src_b), 8'h0);
        chk("b_valid", 8'(out_valid_b), 8'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
